// File: rtl/counter_pkg.sv
// Shared types and helpers for the parametrised up/down counter family.
// Holds the mode enum, the MAX calculation and the parameter legality check.
package counter_pkg;

   typedef enum logic [0:0] {
      MODE_WRAP = 1'b0,
      MODE_SAT  = 1'b1
   } mode_e;

   localparam int MIN_WIDTH       = 32'sd2;
   localparam int MAX_WIDTH       = 32'sd32;
   localparam int MIN_SYNC_STAGES = 32'sd2;

   // Largest reachable count; MODULO of zero means the full 2**WIDTH range.
   function automatic longint calc_max(input int width, input longint modulo);
      longint result;
      if (modulo == 64'sd0) begin
         result = (64'sd1 <<< width) - 64'sd1;
      end else begin
         result = modulo - 64'sd1;
      end
      return result;
   endfunction

   function automatic bit params_ok(input int width, input longint modulo, input int sync_stages);
      bit ok;
      ok = 1'b1;
      if ((width < MIN_WIDTH) || (width > MAX_WIDTH)) begin
         ok = 1'b0;
      end else if ((modulo != 64'sd0) && ((modulo < 64'sd2) || (modulo > (64'sd1 <<< width)))) begin
         ok = 1'b0;
      end else if (sync_stages < MIN_SYNC_STAGES) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/param_updown_counter_checker.sv
// Invariant checker for param_updown_counter, instantiated by the counter itself.
// Watches the next-count bound and the exclusivity of the two pulse outputs.
module param_updown_counter_checker #(
   parameter int WIDTH = 16,
   parameter logic [WIDTH:0] MAX_W = {1'b0, {WIDTH{1'b1}}}
) (
   input logic             clock,
   input logic             resetN,
   input logic [WIDTH:0]   next_ext,
   input logic             tc,
   input logic             load_err
);

   // The wide next-count must never exceed MAX, which also keeps its carry bit clear.
   next_in_range_a : assert property (@(posedge clock) disable iff (!resetN) next_ext <= MAX_W)
      else $error("next count above MAX");

   // A load never produces a terminal count, so the two pulses cannot coincide.
   pulse_exclusive_a : assert property (@(posedge clock) disable iff (!resetN) !(tc && load_err))
      else $error("tc and load_err asserted together");

endmodule

// File: rtl/reset_release_sync.sv
// Asynchronous-assert, synchronous-release reset synchroniser.
// run_en rises SYNC_STAGES clock edges after resetN deasserts.
module reset_release_sync
   import counter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic resetN,
   output logic run_en
);

   if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_stage_err
      $error("reset_release_sync: SYNC_STAGES must be at least 2");
   end

   logic [SYNC_STAGES-1:0] sync_r;

   // Shift a one through the chain once reset is released.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign run_en = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/param_updown_counter.sv
// General-purpose up/down counter with wrap or saturate mode, clear/load and
// terminal-count signalling; inputs are honoured only once run_en is released.
module param_updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH       = 16,
   parameter longint MODULO      = 64'sd0,
   parameter int     SYNC_STAGES = 2
) (
   input  logic             clock,
   input  logic             resetN,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up_down,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             overflow,
   output logic             load_err
);

   if (!params_ok(WIDTH, MODULO, SYNC_STAGES)) begin : g_param_err
      $error("param_updown_counter: illegal WIDTH/MODULO/SYNC_STAGES combination");
   end

   localparam logic [WIDTH:0] MAX_W  = (WIDTH+1)'(calc_max(WIDTH, MODULO));
   localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH:0] ONE_W  = {{WIDTH{1'b0}}, 1'b1};

   logic             run_en_s;
   mode_e            mode_s;
   logic [WIDTH:0]   count_ext_s;
   logic [WIDTH:0]   load_ext_s;
   logic [WIDTH:0]   next_ext_s;
   logic             tc_next_s;
   logic             overflow_next_s;
   logic             load_err_next_s;
   logic [WIDTH-1:0] count_r;
   logic             tc_r;
   logic             overflow_r;
   logic             load_err_r;

   reset_release_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_release (
      .clock  (clock),
      .resetN (resetN),
      .run_en (run_en_s)
   );

   // Next-state selection: clear > load > enable > hold, all at WIDTH+1 bits.
   always_comb begin
      count_ext_s     = {1'b0, count_r};
      load_ext_s      = {1'b0, load_value};
      mode_s          = sat_mode ? MODE_SAT : MODE_WRAP;
      next_ext_s      = count_ext_s;
      tc_next_s       = 1'b0;
      overflow_next_s = overflow_r;
      load_err_next_s = 1'b0;
      if (!run_en_s) begin
         next_ext_s      = ZERO_W;
         overflow_next_s = 1'b0;
      end else if (clear) begin
         next_ext_s      = ZERO_W;
         overflow_next_s = 1'b0;
      end else if (load) begin
         if (load_ext_s > MAX_W) begin
            next_ext_s      = MAX_W;
            load_err_next_s = 1'b1;
         end else begin
            next_ext_s = load_ext_s;
         end
      end else if (enable) begin
         if (up_down) begin
            if (count_ext_s < MAX_W) begin
               next_ext_s = count_ext_s + ONE_W;
            end else begin
               tc_next_s       = 1'b1;
               overflow_next_s = 1'b1;
               case (mode_s)
                  MODE_WRAP: next_ext_s = ZERO_W;
                  MODE_SAT:  next_ext_s = MAX_W;
                  default:   next_ext_s = MAX_W;
               endcase
            end
         end else begin
            if (count_ext_s > ZERO_W) begin
               next_ext_s = count_ext_s - ONE_W;
            end else begin
               tc_next_s       = 1'b1;
               overflow_next_s = 1'b1;
               case (mode_s)
                  MODE_WRAP: next_ext_s = MAX_W;
                  MODE_SAT:  next_ext_s = ZERO_W;
                  default:   next_ext_s = ZERO_W;
               endcase
            end
         end
      end else begin
         next_ext_s = count_ext_s;
      end
   end

   // Output registers; reset is asynchronous so outputs are defined from time zero.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         count_r    <= {WIDTH{1'b0}};
         tc_r       <= 1'b0;
         overflow_r <= 1'b0;
         load_err_r <= 1'b0;
      end else begin
         count_r    <= next_ext_s[WIDTH-1:0];
         tc_r       <= tc_next_s;
         overflow_r <= overflow_next_s;
         load_err_r <= load_err_next_s;
      end
   end

   assign count    = count_r;
   assign tc       = tc_r;
   assign overflow = overflow_r;
   assign load_err = load_err_r;

   param_updown_counter_checker #(
      .WIDTH (WIDTH),
      .MAX_W (MAX_W)
   ) u_checker (
      .clock    (clock),
      .resetN   (resetN),
      .next_ext (next_ext_s),
      .tc       (tc_next_s),
      .load_err (load_err_next_s)
   );

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed testbench for param_updown_counter: a WIDTH=4/MODULO=10 instance
// plus a default-parameter instance for full-range wrap and saturation.
module tb_param_updown_counter;

   logic        clock = 1'b0;
   logic        resetN;
   logic        clear, load, enable, up_down, sat_mode;
   logic [3:0]  load_value;
   logic [3:0]  count;
   logic        tc, overflow, load_err;

   logic        clear16, load16, enable16, up_down16, sat_mode16;
   logic [15:0] load_value16;
   logic [15:0] count16;
   logic        tc16, overflow16, load_err16;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #10 clock = ~clock;

   param_updown_counter #(.WIDTH(4), .MODULO(64'sd10), .SYNC_STAGES(2)) dut (
      .clock(clock), .resetN(resetN), .clear(clear), .load(load),
      .load_value(load_value), .enable(enable), .up_down(up_down),
      .sat_mode(sat_mode), .count(count), .tc(tc), .overflow(overflow),
      .load_err(load_err)
   );

   param_updown_counter dut16 (
      .clock(clock), .resetN(resetN), .clear(clear16), .load(load16),
      .load_value(load_value16), .enable(enable16), .up_down(up_down16),
      .sat_mode(sat_mode16), .count(count16), .tc(tc16), .overflow(overflow16),
      .load_err(load_err16)
   );

   task automatic test_reset();
      resetN = 1'b0;
      clear = 1'b0; load = 1'b0; load_value = 4'd0;
      enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
      clear16 = 1'b0; load16 = 1'b0; load_value16 = 16'd0;
      enable16 = 1'b0; up_down16 = 1'b1; sat_mode16 = 1'b0;
      #1;
      total_cnt++;
      if ({count, tc, overflow, load_err} !== 7'd0) $display("FAIL reset_t0: got %b required 0000000", {count, tc, overflow, load_err});
      else pass_cnt++;
      total_cnt++;
      if (count16 !== 16'd0) $display("FAIL reset_t0_16: got %h required 0000", count16);
      else pass_cnt++;
      #1 resetN = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clock);
         total_cnt++;
         if (count !== ((e == 3) ? 4'd1 : 4'd0)) $display("FAIL release_edge%0d: got %0d required %0d", e, count, (e == 3) ? 1 : 0);
         else pass_cnt++;
      end
      enable = 1'b0;
   endtask

   task automatic test_up_wrap();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      total_cnt++;
      if ({count, overflow} !== 5'b0000_0) $display("FAIL up_clear: got count=%0d ov=%b required 0/0", count, overflow);
      else pass_cnt++;
      enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clock);
         total_cnt++;
         if ({count, tc, overflow} !== {4'(i), 1'b0, 1'b0}) $display("FAIL up_step%0d: got count=%0d tc=%b ov=%b required %0d/0/0", i, count, tc, overflow, i);
         else pass_cnt++;
      end
      @(negedge clock);
      total_cnt++;
      if ({count, tc, overflow} !== {4'd0, 1'b1, 1'b1}) $display("FAIL up_wrap: got count=%0d tc=%b ov=%b required 0/1/1", count, tc, overflow);
      else pass_cnt++;
      @(negedge clock);
      enable = 1'b0;
      total_cnt++;
      if ({count, tc, overflow} !== {4'd1, 1'b0, 1'b1}) $display("FAIL up_after_wrap: got count=%0d tc=%b ov=%b required 1/0/1", count, tc, overflow);
      else pass_cnt++;
   endtask

   task automatic test_down_sat();
      logic [3:0] exp_cnt [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
      logic       exp_tc  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      load = 1'b1; load_value = 4'd2;
      @(negedge clock);
      load = 1'b0;
      total_cnt++;
      if ({count, overflow} !== {4'd2, 1'b0}) $display("FAIL down_load: got count=%0d ov=%b required 2/0", count, overflow);
      else pass_cnt++;
      enable = 1'b1; up_down = 1'b0; sat_mode = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         total_cnt++;
         if ({count, tc} !== {exp_cnt[i], exp_tc[i]}) $display("FAIL down_sat%0d: got count=%0d tc=%b required %0d/%b", i, count, tc, exp_cnt[i], exp_tc[i]);
         else pass_cnt++;
      end
      enable = 1'b0;
      @(negedge clock);
      total_cnt++;
      if ({count, tc, overflow} !== {4'd0, 1'b0, 1'b1}) $display("FAIL down_idle: got count=%0d tc=%b ov=%b required 0/0/1", count, tc, overflow);
      else pass_cnt++;
   endtask

   task automatic test_load_err();
      load = 1'b1; load_value = 4'd12;
      @(negedge clock);
      load = 1'b0;
      total_cnt++;
      if ({count, load_err, overflow} !== {4'd9, 1'b1, 1'b1}) $display("FAIL load_clamp: got count=%0d err=%b ov=%b required 9/1/1", count, load_err, overflow);
      else pass_cnt++;
      enable = 1'b1; up_down = 1'b0; sat_mode = 1'b0;
      @(negedge clock);
      enable = 1'b0;
      total_cnt++;
      if ({count, load_err, tc} !== {4'd8, 1'b0, 1'b0}) $display("FAIL dir_at_max: got count=%0d err=%b tc=%b required 8/0/0", count, load_err, tc);
      else pass_cnt++;
      clear = 1'b1; load = 1'b1; load_value = 4'd12;
      @(negedge clock);
      clear = 1'b0; load = 1'b0;
      total_cnt++;
      if ({count, load_err, overflow} !== {4'd0, 1'b0, 1'b0}) $display("FAIL clear_wins: got count=%0d err=%b ov=%b required 0/0/0", count, load_err, overflow);
      else pass_cnt++;
   endtask

   task automatic test_default_params();
      load16 = 1'b1; load_value16 = 16'hFFFF; up_down16 = 1'b1; sat_mode16 = 1'b0;
      @(negedge clock);
      load16 = 1'b0; enable16 = 1'b1;
      total_cnt++;
      if (count16 !== 16'hFFFF) $display("FAIL wide_load: got %h required ffff", count16);
      else pass_cnt++;
      @(negedge clock);
      enable16 = 1'b0;
      total_cnt++;
      if ({count16, tc16, overflow16} !== {16'h0000, 1'b1, 1'b1}) $display("FAIL wide_wrap: got %h tc=%b ov=%b required 0000/1/1", count16, tc16, overflow16);
      else pass_cnt++;
      load16 = 1'b1; sat_mode16 = 1'b1;
      @(negedge clock);
      load16 = 1'b0; enable16 = 1'b1;
      @(negedge clock);
      enable16 = 1'b0;
      total_cnt++;
      if ({count16, tc16} !== {16'hFFFF, 1'b1}) $display("FAIL wide_sat: got %h tc=%b required ffff/1", count16, tc16);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0; enable = 1'b1; up_down = 1'b1; sat_mode = 1'b0;
      repeat (7) @(negedge clock);
      total_cnt++;
      if (count !== 4'd7) $display("FAIL pre_reset: got %0d required 7", count);
      else pass_cnt++;
      #2 resetN = 1'b0;
      #1;
      total_cnt++;
      if ({count, tc, overflow} !== {4'd0, 1'b0, 1'b0}) $display("FAIL async_reset: got count=%0d tc=%b ov=%b required 0/0/0", count, tc, overflow);
      else pass_cnt++;
      total_cnt++;
      if (count16 !== 16'd0) $display("FAIL async_reset_16: got %h required 0000", count16);
      else pass_cnt++;
      #2 resetN = 1'b1;
      for (int e = 1; e <= 3; e++) begin
         @(negedge clock);
         total_cnt++;
         if (count !== ((e == 3) ? 4'd1 : 4'd0)) $display("FAIL rerelease_edge%0d: got %0d required %0d", e, count, (e == 3) ? 1 : 0);
         else pass_cnt++;
      end
      enable = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_sat();
      test_load_err();
      test_default_params();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
